// File: rtl/addsub_if.sv
// addsub_if: operand/result handshake bundle for nibble_serial_addsub (overflow under ADDSUB_OVF_EN)
interface addsub_if #(parameter int WIDTH = 16);
  logic in_valid;
  logic in_ready;
  logic op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] result;
  logic carry_out;
`ifdef ADDSUB_OVF_EN
  logic overflow;
  modport master(output in_valid, op_sub, a, b, out_ready,
                 input in_ready, out_valid, result, carry_out, overflow);
  modport slave(input in_valid, op_sub, a, b, out_ready,
                output in_ready, out_valid, result, carry_out, overflow);
`else
  modport master(output in_valid, op_sub, a, b, out_ready,
                 input in_ready, out_valid, result, carry_out);
  modport slave(input in_valid, op_sub, a, b, out_ready,
                output in_ready, out_valid, result, carry_out);
`endif
endinterface

// File: rtl/nibble_serial_addsub.sv
// nibble_serial_addsub: WIDTH-bit add/sub through one 4-bit adder, one nibble per cycle; ADDSUB_OVF_EN adds signed overflow
module nibble_adder4 (
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic       cin1,
  input  logic       cin2,
  output logic [3:0] out,
  output logic       co
);
  // cin1 is the carry-in; cin1^cin2 selects true in2, otherwise in2 is inverted
  logic [3:0] opnd;
  assign opnd = (cin1 ^ cin2) ? in2 : ~in2;
  assign {co, out} = {1'b0, in1} + {1'b0, opnd} + {4'b0, cin1};
endmodule

module nibble_serial_addsub #(parameter int WIDTH = 16) (
  input logic clk,
  input logic rst,
  addsub_if.slave bus
);
  localparam int NIB = WIDTH / 4;
  localparam int CW = $clog2(NIB);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic [CW-1:0] nib_cnt;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic sub_q, c_q, vld_q, last;
  logic [3:0] a_n, b_n, in2, sum;
  logic cin2, co;
  assign a_n = 4'(a_q >> {nib_cnt, 2'b00});
  assign b_n = 4'(b_q >> {nib_cnt, 2'b00});
  assign in2 = (!sub_q && !c_q) ? ~b_n : b_n;
  assign cin2 = sub_q & c_q;
  assign last = nib_cnt == CW'(NIB - 1);
  nibble_adder4 u_add (.in1(a_n), .in2(in2), .cin1(c_q), .cin2(cin2), .out(sum), .co(co));
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = vld_q;
  assign bus.result = res_q;
  assign bus.carry_out = c_q;
`ifdef ADDSUB_OVF_EN
  logic ov_q;
  assign bus.overflow = ov_q;
  // carry into the MSB is recovered from the sign bits of a, effective b and the result
  always_ff @(posedge clk or posedge rst)
    if (rst) ov_q <= 1'b0;
    else if (state == RUN && last) ov_q <= a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sub_q ^ sum[3] ^ co;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      nib_cnt <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      sub_q <= 1'b0;
      c_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a_q <= bus.a;
          b_q <= bus.b;
          sub_q <= bus.op_sub;
          c_q <= bus.op_sub;
          nib_cnt <= '0;
          state <= RUN;
        end
        RUN: begin
          res_q[{nib_cnt, 2'b00} +: 4] <= sum;
          c_q <= co;
          nib_cnt <= nib_cnt + 1'b1;
          if (last) state <= DONE;
        end
        DONE: if (vld_q && bus.out_ready) begin
          vld_q <= 1'b0;
          state <= IDLE;
        end else vld_q <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// tb_nibble_serial_addsub: directed + random add/sub checks against an arithmetic reference model
module tb_nibble_serial_addsub;
  logic clk = 0;
  logic rst = 1;
  int vec = 0;
  int bad = 0;
  addsub_if #(16) bus();
  nibble_serial_addsub #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic [15:0] er, input logic ec, input logic eo);
    int lat;
    bus.a = a;
    bus.b = b;
    bus.op_sub = sub;
    bus.in_valid = 1;
    step();
    bus.in_valid = 0;
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
    bus.op_sub = ~sub;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
    check("latency", lat, 5);
    check("result", bus.result, er);
    check("carry_out", bus.carry_out, ec);
`ifdef ADDSUB_OVF_EN
    check("overflow", bus.overflow, eo);
`else
    if (eo === 1'bx) check("overflow_unused", 0, 1);
`endif
    bus.out_ready = 1;
    step();
    bus.out_ready = 0;
    check("out_valid_drop", bus.out_valid, 0);
    check("in_ready_back", bus.in_ready, 1);
  endtask

  task automatic model_op(input logic [15:0] a, input logic [15:0] b, input logic sub);
    logic [16:0] full;
    logic [15:0] r;
    logic c, o;
    full = sub ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
    r = full[15:0];
    c = sub ? (a >= b) : full[16];
    o = sub ? (a[15] != b[15] && r[15] != a[15]) : (a[15] == b[15] && r[15] != a[15]);
    run_op(a, b, sub, r, c, o);
  endtask

  initial begin
    logic [15:0] held;
    bus.in_valid = 0;
    bus.out_ready = 0;
    bus.op_sub = 0;
    bus.a = 0;
    bus.b = 0;
    #2;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_carry", bus.carry_out, 0);
    step();
    rst = 0;
    step();
    run_op(16'h1234, 16'h0FCD, 0, 16'h2201, 0, 0);
    run_op(16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0);
    run_op(16'h0003, 16'h0005, 1, 16'hFFFE, 0, 0);
    run_op(16'h8000, 16'h8000, 1, 16'h0000, 1, 0);
    run_op(16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1);
    model_op(16'h8000, 16'h0001, 1);
    for (int i = 0; i < 25; i++) model_op(16'($urandom), 16'($urandom), 1'($urandom));
    // abort mid-RUN
    bus.a = 16'h5555;
    bus.b = 16'h1111;
    bus.op_sub = 0;
    bus.in_valid = 1;
    step();
    bus.in_valid = 0;
    step();
    step();
    rst = 1;
    #1;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_result", bus.result, 0);
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_carry", bus.carry_out, 0);
    step();
    rst = 0;
    step();
    model_op(16'h1234, 16'h4321, 1);
    // hold in DONE with out_ready low; new requests must be ignored
    bus.a = 16'h00F0;
    bus.b = 16'h0F0F;
    bus.op_sub = 0;
    bus.in_valid = 1;
    step();
    bus.in_valid = 0;
    for (int i = 0; i < 20 && !bus.out_valid; i++) step();
    held = bus.result;
    check("hold_first", held, 16'h0FFF);
    bus.in_valid = 1;
    bus.a = 16'hAAAA;
    bus.b = 16'h5555;
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_result", bus.result, 16'h0FFF);
      check("hold_in_ready", bus.in_ready, 0);
      check("hold_out_valid", bus.out_valid, 1);
    end
    bus.in_valid = 0;
    bus.out_ready = 1;
    step();
    bus.out_ready = 0;
    check("release_in_ready", bus.in_ready, 1);
    check("release_out_valid", bus.out_valid, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      check("no_queue", bus.out_valid, 0);
    end
    bus.out_ready = 1;
    step();
    step();
    check("idle_ready_ignored", bus.in_ready, 1);
    bus.out_ready = 0;
    model_op(16'hFFFF, 16'hFFFF, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
